// File: rtl/avst_sink_pkg.sv
// Shared types and register map for the Avalon-ST packet sink.
// Framing states, CSR word addresses and CTRL/STATUS bit positions.
package avst_sink_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_IN_PKT = 1'b1
  } state_e;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PKT    = 3'd1;
  localparam logic [2:0] A_BYTE   = 3'd2;
  localparam logic [2:0] A_ERR    = 3'd3;
  localparam logic [2:0] A_LAST   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_BP     = 3'd6;
  localparam logic [2:0] A_RSVD   = 3'd7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int STAT_INPKT  = 0;
  localparam int STAT_STICKY = 1;

endpackage

// File: rtl/avst_packet_sink_csr.sv
// CSR block: decode, CTRL/BP_PATTERN/sticky state, 1-cycle read pipe.
// A read in the same cycle as a write wins; the write is dropped.
module avst_packet_sink_csr
  import avst_sink_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        csr_readdatavalid,
  input  logic [31:0] pkt_count,
  input  logic [31:0] byte_count,
  input  logic [31:0] err_count,
  input  logic [31:0] last_len,
  input  logic        in_packet,
  input  logic        err_event,
  output logic        enable,
  output logic        clear,
  output logic [31:0] bp_pattern
);

  logic        wr_en;
  logic        sticky_err;
  logic [31:0] rd_mux;

  assign wr_en = csr_write & ~csr_read;
  assign clear = wr_en & (csr_address == A_CTRL)
               & csr_writedata[CTRL_CLR];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable     <= 1'b0;
      bp_pattern <= 32'hFFFF_FFFF;
      sticky_err <= 1'b0;
    end else begin
      if (wr_en && csr_address == A_CTRL)
        enable <= csr_writedata[CTRL_EN];
      if (wr_en && csr_address == A_BP)
        bp_pattern <= csr_writedata;
      // a fresh error outranks a W1C landing in the same cycle
      if (clear)
        sticky_err <= 1'b0;
      else if (err_event)
        sticky_err <= 1'b1;
      else if (wr_en && csr_address == A_STATUS
               && csr_writedata[STAT_STICKY])
        sticky_err <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      A_CTRL:   rd_mux[CTRL_EN] = enable;
      A_PKT:    rd_mux = pkt_count;
      A_BYTE:   rd_mux = byte_count;
      A_ERR:    rd_mux = err_count;
      A_LAST:   rd_mux = last_len;
      A_STATUS: begin
        rd_mux[STAT_INPKT]  = in_packet;
        rd_mux[STAT_STICKY] = sticky_err;
      end
      A_BP:     rd_mux = bp_pattern;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      csr_readdatavalid <= csr_read;
      if (csr_read)
        csr_readdata <= rd_mux;
    end
  end

endmodule

// File: rtl/avst_packet_sink.sv
// Avalon-ST packet sink: framing checks, packet/byte/error counters,
// programmable backpressure pattern, CSR access via avst_packet_sink_csr.
module avst_packet_sink
  import avst_sink_pkg::*;
#(
  parameter  int DATA_BYTES = 8,
  localparam int EMPTY_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_BYTES*8-1:0] stream_in_data,
  input  logic [EMPTY_W-1:0]      stream_in_empty,
  input  logic                    stream_in_valid,
  input  logic                    stream_in_startofpacket,
  input  logic                    stream_in_endofpacket,
  output logic                    stream_in_ready,
  input  logic [2:0]              csr_address,
  input  logic                    csr_read,
  input  logic                    csr_write,
  input  logic [31:0]             csr_writedata,
  output logic [31:0]             csr_readdata,
  output logic                    csr_readdatavalid,
  output logic                    csr_waitrequest
);

  state_e      state_q, state_d;
  logic [4:0]  bp_ptr;
  logic [31:0] pkt_count, pkt_d;
  logic [31:0] byte_count, byte_d;
  logic [31:0] err_count, err_d;
  logic [31:0] last_len, last_d;
  logic [31:0] run_len, run_d;
  logic [31:0] beat_bytes, len;
  logic        enable, clear, err_event;
  logic        accept, orphan, trunc, empty_err;
  logic [31:0] bp_pattern;
  logic        unused_data;

  assign unused_data     = ^stream_in_data;
  assign csr_waitrequest = 1'b0;
  assign stream_in_ready = enable & bp_pattern[bp_ptr];
  assign accept          = stream_in_valid & stream_in_ready;

  assign beat_bytes = stream_in_endofpacket
    ? 32'(DATA_BYTES) - 32'(stream_in_empty)
    : 32'(DATA_BYTES);

  assign orphan    = (state_q == S_IDLE) & ~stream_in_startofpacket;
  assign trunc     = (state_q == S_IN_PKT) & stream_in_startofpacket;
  assign empty_err = ~stream_in_endofpacket & (stream_in_empty != '0);

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_count;
    byte_d    = byte_count;
    err_d     = err_count;
    last_d    = last_len;
    run_d     = run_len;
    err_event = 1'b0;
    len       = stream_in_startofpacket ? beat_bytes
                                        : run_len + beat_bytes;
    if (accept) begin
      byte_d    = byte_count + beat_bytes;
      err_event = orphan | trunc | empty_err;
      err_d     = err_count + 32'(err_event);
      // an orphan beat touches nothing but the byte and error counts
      if (!orphan) begin
        if (stream_in_endofpacket) begin
          pkt_d   = pkt_count + 32'd1;
          last_d  = len;
          run_d   = '0;
          state_d = S_IDLE;
        end else begin
          run_d   = len;
          state_d = S_IN_PKT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pkt_count  <= '0;
      byte_count <= '0;
      err_count  <= '0;
      last_len   <= '0;
      run_len    <= '0;
    end else if (clear) begin
      state_q    <= S_IDLE;
      pkt_count  <= '0;
      byte_count <= '0;
      err_count  <= '0;
      last_len   <= '0;
      run_len    <= '0;
    end else begin
      state_q    <= state_d;
      pkt_count  <= pkt_d;
      byte_count <= byte_d;
      err_count  <= err_d;
      last_len   <= last_d;
      run_len    <= run_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bp_ptr <= '0;
    else
      bp_ptr <= bp_ptr + 5'd1;
  end

  avst_packet_sink_csr u_csr (
    .clk               (clk),
    .reset             (reset),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .pkt_count         (pkt_count),
    .byte_count        (byte_count),
    .err_count         (err_count),
    .last_len          (last_len),
    .in_packet         (state_q == S_IN_PKT),
    .err_event         (err_event),
    .enable            (enable),
    .clear             (clear),
    .bp_pattern        (bp_pattern)
  );

endmodule

// File: tb/tb_avst_packet_sink.sv
// Bench for avst_packet_sink: packet-level reference model checked every
// cycle, plus directed register reads with hand-computed values.
module tb_avst_packet_sink;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DB*8-1:0] stream_in_data = '0;
  logic [2:0]    stream_in_empty = '0;
  logic          stream_in_valid = 1'b0;
  logic          stream_in_startofpacket = 1'b0;
  logic          stream_in_endofpacket = 1'b0;
  logic          stream_in_ready;
  logic [2:0]    csr_address = '0;
  logic          csr_read = 1'b0;
  logic          csr_write = 1'b0;
  logic [31:0]   csr_writedata = '0;
  logic [31:0]   csr_readdata;
  logic          csr_readdatavalid;
  logic          csr_waitrequest;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  avst_packet_sink #(.DATA_BYTES(DB)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .stream_in_data          (stream_in_data),
    .stream_in_empty         (stream_in_empty),
    .stream_in_valid         (stream_in_valid),
    .stream_in_startofpacket (stream_in_startofpacket),
    .stream_in_endofpacket   (stream_in_endofpacket),
    .stream_in_ready         (stream_in_ready),
    .csr_address             (csr_address),
    .csr_read                (csr_read),
    .csr_write               (csr_write),
    .csr_writedata           (csr_writedata),
    .csr_readdata            (csr_readdata),
    .csr_readdatavalid       (csr_readdatavalid),
    .csr_waitrequest         (csr_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference model: packet = list of beat sizes, counters as plain sums
  bit          m_en, m_open, m_sticky, m_rv;
  logic [31:0] m_bp, m_pkt, m_byte, m_err, m_last, m_rd;
  logic [4:0]  m_ptr;
  int          m_beats[$];

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0: return {31'd0, m_en};
      3'd1: return m_pkt;
      3'd2: return m_byte;
      3'd3: return m_err;
      3'd4: return m_last;
      3'd5: return {30'd0, m_sticky, m_open};
      3'd6: return m_bp;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en = 0; m_open = 0; m_sticky = 0; m_rv = 0;
      m_bp = 32'hFFFF_FFFF; m_pkt = 0; m_byte = 0; m_err = 0;
      m_last = 0; m_rd = 0; m_ptr = 0;
      m_beats.delete();
    end else begin
      bit acc, clr, err, wr;
      int nb, sum;
      acc = stream_in_valid && m_en && m_bp[m_ptr];
      wr  = csr_write && !csr_read;
      clr = wr && csr_address == 3'd0 && csr_writedata[1];
      m_rv = csr_read;
      if (csr_read) m_rd = m_reg(csr_address);
      if (wr && csr_address == 3'd0) m_en = csr_writedata[0];
      if (wr && csr_address == 3'd6) m_bp = csr_writedata;
      if (wr && csr_address == 3'd5 && csr_writedata[1]) m_sticky = 0;
      if (clr) begin
        m_pkt = 0; m_byte = 0; m_err = 0; m_last = 0;
        m_open = 0; m_sticky = 0; m_beats.delete();
      end else if (acc) begin
        nb = stream_in_endofpacket ? DB - int'(stream_in_empty) : DB;
        m_byte += 32'(nb);
        err = (!m_open && !stream_in_startofpacket)
           || (m_open && stream_in_startofpacket)
           || (!stream_in_endofpacket && stream_in_empty != 0);
        if (m_open || stream_in_startofpacket) begin
          if (stream_in_startofpacket) m_beats.delete();
          m_beats.push_back(nb);
          if (stream_in_endofpacket) begin
            sum = 0;
            foreach (m_beats[i]) sum += m_beats[i];
            m_pkt++; m_last = 32'(sum);
            m_beats.delete(); m_open = 0;
          end else m_open = 1;
        end
        if (err) begin m_err++; m_sticky = 1; end
      end
      m_ptr = m_ptr + 5'd1;
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("ready", 32'(stream_in_ready), 32'(m_en & m_bp[m_ptr]));
      chk("rdvalid", 32'(csr_readdatavalid), 32'(m_rv));
      chk("rddata", csr_readdata, m_rd);
      chk("waitreq", 32'(csr_waitrequest), 32'd0);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1;
    @(negedge clk);
    csr_write = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                    input string nm);
    csr_address = a; csr_read = 1;
    @(negedge clk);
    csr_read = 0;
    chk({nm, "_valid"}, 32'(csr_readdatavalid), 32'd1);
    chk(nm, csr_readdata, exp);
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string nm);
    csr_address = a; csr_writedata = d; csr_read = 1; csr_write = 1;
    @(negedge clk);
    csr_read = 0; csr_write = 0;
    chk({nm, "_valid"}, 32'(csr_readdatavalid), 32'd1);
    chk(nm, csr_readdata, exp);
  endtask

  task automatic send(input bit sop, input bit eop, input int emp);
    int n = 0;
    stream_in_valid = 1;
    stream_in_startofpacket = sop;
    stream_in_endofpacket = eop;
    stream_in_empty = 3'(emp);
    stream_in_data = {$urandom, $urandom};
    while (!stream_in_ready && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    stream_in_valid = 0;
    stream_in_startofpacket = 0;
    stream_in_endofpacket = 0;
    stream_in_empty = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    started = 1;
    chk("rst_ready", 32'(stream_in_ready), 32'd0);
    chk("rst_rdvalid", 32'(csr_readdatavalid), 32'd0);
    chk("rst_rddata", csr_readdata, 32'd0);
    rd(3'd6, 32'hFFFF_FFFF, "rst_bp");
    rd(3'd1, 32'd0, "rst_pkt");
    rd(3'd0, 32'd0, "rst_ctrl");

    // 3-beat packet, 5 bytes in the last beat
    wr(3'd0, 32'd1);
    send(1, 0, 0); send(0, 0, 0); send(0, 1, 3);
    rd(3'd1, 32'd1, "p1_pkt");
    rd(3'd2, 32'd21, "p1_byte");
    rd(3'd4, 32'd21, "p1_last");
    rd(3'd3, 32'd0, "p1_err");
    rd(3'd5, 32'd0, "p1_status");

    // orphan beat, then a clean single-beat packet
    wr(3'd0, 32'd3);
    rd(3'd0, 32'd1, "ctrl_clr_selfclr");
    send(0, 0, 0); send(1, 1, 0);
    rd(3'd3, 32'd1, "orph_err");
    rd(3'd1, 32'd1, "orph_pkt");
    rd(3'd2, 32'd16, "orph_byte");
    rd(3'd5, 32'd2, "orph_sticky");
    wr(3'd5, 32'd2);
    rd(3'd5, 32'd0, "w1c_sticky");

    // truncated packet restarted by a second SOP
    wr(3'd0, 32'd3);
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(0, 1, 0);
    rd(3'd3, 32'd1, "trunc_err");
    rd(3'd1, 32'd1, "trunc_pkt");
    rd(3'd4, 32'd16, "trunc_last");
    rd(3'd2, 32'd32, "trunc_byte");

    // non-EOP beat carrying empty: still counted as full width
    wr(3'd0, 32'd3);
    send(1, 0, 0); send(0, 0, 2); send(0, 1, 1);
    rd(3'd3, 32'd1, "empty_err");
    rd(3'd4, 32'd23, "empty_last");

    // disable mid-packet, then resume
    wr(3'd0, 32'd3);
    send(1, 0, 0);
    rd(3'd5, 32'd1, "inpkt_status");
    wr(3'd0, 32'd0);
    repeat (4) @(negedge clk);
    wr(3'd0, 32'd1);
    send(0, 1, 0);
    rd(3'd1, 32'd1, "resume_pkt");
    rd(3'd4, 32'd16, "resume_last");
    rd(3'd3, 32'd0, "resume_err");

    // alternating backpressure over 32 cycles accepts 16 beats
    wr(3'd0, 32'd3);
    wr(3'd6, 32'h5555_5555);
    stream_in_valid = 1;
    stream_in_startofpacket = 1;
    stream_in_endofpacket = 1;
    repeat (32) @(negedge clk);
    stream_in_valid = 0;
    stream_in_startofpacket = 0;
    stream_in_endofpacket = 0;
    rd(3'd1, 32'd16, "bp_pkt");
    rd(3'd2, 32'd128, "bp_byte");
    wr(3'd6, 32'hFFFF_FFFF);

    // read and write together: read wins, write dropped
    wr(3'd0, 32'd3);
    send(1, 1, 0);
    rdwr(3'd1, 32'd7, 32'd1, "rw_pkt");
    rdwr(3'd6, 32'd0, 32'hFFFF_FFFF, "rw_bp");
    rd(3'd6, 32'hFFFF_FFFF, "rw_bp_kept");
    rdwr(3'd0, 32'd2, 32'd1, "rw_ctrl");
    rd(3'd1, 32'd1, "rw_noclr_pkt");
    rd(3'd7, 32'd0, "rsvd");

    // clear coincident with an accepted beat
    stream_in_valid = 1;
    stream_in_startofpacket = 1;
    stream_in_endofpacket = 1;
    chk("clr_acc_ready", 32'(stream_in_ready), 32'd1);
    wr(3'd0, 32'd3);
    stream_in_valid = 0;
    stream_in_startofpacket = 0;
    stream_in_endofpacket = 0;
    rd(3'd1, 32'd0, "clr_pkt");
    rd(3'd2, 32'd0, "clr_byte");
    rd(3'd4, 32'd0, "clr_last");

    // reset in the middle of a packet, then resend it
    send(1, 0, 0); send(0, 0, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst2_ready", 32'(stream_in_ready), 32'd0);
    wr(3'd0, 32'd1);
    send(1, 0, 0); send(0, 1, 0);
    rd(3'd1, 32'd1, "rst2_pkt");
    rd(3'd3, 32'd0, "rst2_err");
    rd(3'd2, 32'd16, "rst2_byte");
    rd(3'd5, 32'd0, "rst2_status");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
